// File: rtl/legv8_pkg.sv
// Shared LEGv8 register-file constants and the write-back entry format.
package legv8_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 64;
   localparam int NREG   = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] XZR = 5'd31;

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order write-back queue: two ordered push ports, one pop, plus a vector of
// destinations that still have a queued entry behind the current head.
module wb_fifo
   import legv8_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_push0,
   input  wb_entry_t       i_entry0,
   input  logic            i_push1,
   input  wb_entry_t       i_entry1,
   input  logic            i_pop,
   output wb_entry_t       o_head,
   output logic [CW-1:0]   o_count,
   output logic [NREG-1:0] o_younger
);

   wb_entry_t     r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [PW-1:0] w_slot1;

   // Port 0 always lands first, so port 1 takes the following slot when both push.
   assign w_slot1 = i_push0 ? (r_wr_ptr + PW'(1)) : r_wr_ptr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + PW'(i_push0) + PW'(i_push1);
         r_rd_ptr <= r_rd_ptr + PW'(i_pop);
         r_count  <= r_count + CW'(i_push0) + CW'(i_push1) - CW'(i_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (i_push0) r_mem[r_wr_ptr] <= i_entry0;
      if (i_push1) r_mem[w_slot1]  <= i_entry1;
   end

   always_comb begin
      logic [PW-1:0] w_idx;
      w_idx     = '0;
      o_younger = '0;
      for (int i = 1; i < DEPTH; i++) begin
         w_idx = r_rd_ptr + PW'(i);
         if (CW'(i) < r_count) o_younger[r_mem[w_idx].rd] = 1'b1;
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/regfile_writeback_unit.sv
// Write-side front end of the LEGv8 register file: merges load and ALU results
// in order, drives the single write port and tracks pending destinations.
module regfile_writeback_unit
   import legv8_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] ZERO_REG = XZR
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_rd,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   output logic              rf_write_en,
   output logic [ADDR_W-1:0] rf_write_add,
   output logic [DATA_W-1:0] rf_write_data,
   output logic [NREG-1:0]   busy
);

   localparam int CW = $clog2(DEPTH + 1);

   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_add;
   logic [DATA_W-1:0] r_wr_data;
   logic [NREG-1:0]   r_busy;

   logic [CW-1:0]     w_count;
   logic [NREG-1:0]   w_younger;
   wb_entry_t         w_head;
   wb_entry_t         w_mem_entry;
   wb_entry_t         w_alu_entry;
   logic              w_mem_acc;
   logic              w_alu_acc;
   logic              w_mem_push;
   logic              w_alu_push;
   logic              w_pop;
   logic              w_clr;
   logic [NREG-1:0]   w_busy_next;

   // Handshake: a result transfers on a cycle where valid & ready are both high.
   // Ready depends only on the registered occupancy, never on valid, so there is
   // no combinational path from a producer's valid back to its ready.
   assign mem_ready = (w_count <= CW'(DEPTH - 1));
   assign alu_ready = (w_count <= CW'(DEPTH - 2));

   assign w_mem_acc  = mem_valid & mem_ready;
   assign w_alu_acc  = alu_valid & alu_ready;
   assign w_mem_push = w_mem_acc & (mem_rd != ZERO_REG);
   assign w_alu_push = w_alu_acc & (alu_rd != ZERO_REG);
   assign w_pop      = (w_count != '0);

   assign w_mem_entry = '{rd: mem_rd, data: mem_data};
   assign w_alu_entry = '{rd: alu_rd, data: alu_data};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .i_push0   (w_mem_push),
      .i_entry0  (w_mem_entry),
      .i_push1   (w_alu_push),
      .i_entry1  (w_alu_entry),
      .i_pop     (w_pop),
      .o_head    (w_head),
      .o_count   (w_count),
      .o_younger (w_younger)
   );

   // The popped rd stays busy if another write to it is queued or entering now.
   assign w_clr = w_pop && !w_younger[w_head.rd]
                  && !(w_mem_push && (mem_rd == w_head.rd))
                  && !(w_alu_push && (alu_rd == w_head.rd));

   always_comb begin
      w_busy_next = r_busy;
      if (w_clr) w_busy_next[w_head.rd] = 1'b0;
      if (issue_valid && (issue_rd != ZERO_REG)) w_busy_next[issue_rd] = 1'b1;
      w_busy_next[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_en   <= 1'b0;
         r_wr_add  <= '0;
         r_wr_data <= '0;
         r_busy    <= '0;
      end else begin
         r_wr_en <= w_pop;
         if (w_pop) begin
            r_wr_add  <= w_head.rd;
            r_wr_data <= w_head.data;
         end
         r_busy <= w_busy_next;
      end
   end

   assign rf_write_en   = r_wr_en;
   assign rf_write_add  = r_wr_add;
   assign rf_write_data = r_wr_data;
   assign busy          = r_busy;

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Directed bench for regfile_writeback_unit: timing, ordering, XZR filtering,
// scoreboard set/clear priority and mid-operation reset.
module tb_regfile_writeback_unit;
   import legv8_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_rd;
   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_rd;
   logic [DATA_W-1:0] mem_data;
   logic              alu_valid;
   logic              alu_ready;
   logic [ADDR_W-1:0] alu_rd;
   logic [DATA_W-1:0] alu_data;
   logic              rf_write_en;
   logic [ADDR_W-1:0] rf_write_add;
   logic [DATA_W-1:0] rf_write_data;
   logic [NREG-1:0]   busy;

   int n_vec = 0;
   int n_err = 0;
   logic sb_on = 1'b0;
   logic [ADDR_W+DATA_W-1:0] exp_q[$];

   regfile_writeback_unit dut (
      .clk           (clk),
      .reset         (reset),
      .issue_valid   (issue_valid),
      .issue_rd      (issue_rd),
      .mem_valid     (mem_valid),
      .mem_ready     (mem_ready),
      .mem_rd        (mem_rd),
      .mem_data      (mem_data),
      .alu_valid     (alu_valid),
      .alu_ready     (alu_ready),
      .alu_rd        (alu_rd),
      .alu_data      (alu_data),
      .rf_write_en   (rf_write_en),
      .rf_write_add  (rf_write_add),
      .rf_write_data (rf_write_data),
      .busy          (busy)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: timeout reached, actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      issue_valid = 1'b0;
      issue_rd    = '0;
      mem_valid   = 1'b0;
      mem_rd      = '0;
      mem_data    = '0;
      alu_valid   = 1'b0;
      alu_rd      = '0;
      alu_data    = '0;
   endtask

   // scoreboard: every write seen while enabled must match the expected order
   always @(negedge clk) begin
      if (sb_on && rf_write_en) begin
         if (exp_q.size() == 0) begin
            check("sb_extra_write", 64'(rf_write_add), 64'hFFFF);
         end else begin
            logic [ADDR_W+DATA_W-1:0] e;
            e = exp_q.pop_front();
            check("sb_add", 64'(rf_write_add), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
            check("sb_data", rf_write_data, e[DATA_W-1:0]);
         end
      end
   end

   initial begin
      int cnt_m;
      int mi, ai, bound;
      logic ma, aa;

      reset = 1'b1;
      drive_idle();
      tick();
      tick();
      check("rst_wr_en", 64'(rf_write_en), 64'd0);
      check("rst_wr_add", 64'(rf_write_add), 64'd0);
      check("rst_wr_data", rf_write_data, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_mem_ready", 64'(mem_ready), 64'd1);
      check("rst_alu_ready", 64'(alu_ready), 64'd1);
      reset = 1'b0;
      tick();

      // single ALU result: visible one edge after the acceptance edge
      issue_valid = 1'b1; issue_rd = 5'd3;
      tick();
      issue_valid = 1'b0;
      check("t1_busy_set", 64'(busy[3]), 64'd1);
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h1234;
      tick();
      drive_idle();
      check("t1_no_bypass", 64'(rf_write_en), 64'd0);
      check("t1_busy_held", 64'(busy[3]), 64'd1);
      tick();
      check("t1_wr_en", 64'(rf_write_en), 64'd1);
      check("t1_wr_add", 64'(rf_write_add), 64'd3);
      check("t1_wr_data", rf_write_data, 64'h1234);
      check("t1_busy_clr", 64'(busy[3]), 64'd0);
      tick();
      check("t1_wr_en_drop", 64'(rf_write_en), 64'd0);
      check("t1_add_hold", 64'(rf_write_add), 64'd3);

      // same rd from both ports: load first, busy held until the ALU value lands
      issue_valid = 1'b1; issue_rd = 5'd5;
      tick();
      issue_valid = 1'b0;
      mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 64'hAA;
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hBB;
      tick();
      drive_idle();
      check("t2_busy_a", 64'(busy[5]), 64'd1);
      tick();
      check("t2_first_en", 64'(rf_write_en), 64'd1);
      check("t2_first_add", 64'(rf_write_add), 64'd5);
      check("t2_first_data", rf_write_data, 64'hAA);
      check("t2_busy_b", 64'(busy[5]), 64'd1);
      tick();
      check("t2_second_en", 64'(rf_write_en), 64'd1);
      check("t2_second_data", rf_write_data, 64'hBB);
      check("t2_busy_clr", 64'(busy[5]), 64'd0);
      tick();
      check("t2_idle", 64'(rf_write_en), 64'd0);

      // XZR: consumed, never written, never busy
      issue_valid = 1'b1; issue_rd = 5'd31;
      alu_valid = 1'b1; alu_rd = 5'd31; alu_data = 64'hFFFF;
      tick();
      drive_idle();
      check("t4_busy31_a", 64'(busy[31]), 64'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t4_no_write", 64'(rf_write_en), 64'd0);
         check("t4_busy31", 64'(busy[31]), 64'd0);
      end

      // set and clear of rd=7 on the same edge: set wins
      issue_valid = 1'b1; issue_rd = 5'd7;
      tick();
      issue_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h77;
      tick();
      drive_idle();
      issue_valid = 1'b1; issue_rd = 5'd7;
      tick();
      issue_valid = 1'b0;
      check("t5_wr_add", 64'(rf_write_add), 64'd7);
      check("t5_busy_set_wins", 64'(busy[7]), 64'd1);
      tick();
      check("t5_busy_stays", 64'(busy[7]), 64'd1);

      // streaming both ports: ready thresholds and order via scoreboard
      sb_on = 1'b1;
      cnt_m = 0; mi = 0; ai = 0;
      while (mi < 10 || ai < 10) begin
         mem_valid = (mi < 10); mem_rd = 5'(8 + mi % 8);  mem_data = 64'h1000 + 64'(mi);
         alu_valid = (ai < 10); alu_rd = 5'(16 + ai % 8); alu_data = 64'h2000 + 64'(ai);
         check("t3_mem_ready", 64'(mem_ready), 64'(cnt_m <= 3));
         check("t3_alu_ready", 64'(alu_ready), 64'(cnt_m <= 2));
         ma = mem_valid && (cnt_m <= 3);
         aa = alu_valid && (cnt_m <= 2);
         if (ma) exp_q.push_back({mem_rd, mem_data});
         if (aa) exp_q.push_back({alu_rd, alu_data});
         cnt_m = cnt_m + int'(ma) + int'(aa) - int'(cnt_m > 0);
         tick();
         if (ma) mi++;
         if (aa) ai++;
      end
      drive_idle();
      bound = 0;
      while (exp_q.size() != 0 && bound < 50) begin
         tick();
         bound++;
      end
      check("t3_drain", 64'(exp_q.size()), 64'd0);
      tick();
      sb_on = 1'b0;

      // reset with three entries queued
      issue_valid = 1'b1; issue_rd = 5'd9;
      mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 64'h1;
      alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 64'h2;
      tick();
      issue_valid = 1'b0;
      mem_rd = 5'd12; mem_data = 64'h3;
      alu_rd = 5'd13; alu_data = 64'h4;
      check("t6_alu_ready_pre", 64'(alu_ready), 64'd1);
      tick();
      drive_idle();
      check("t6_alu_ready_full", 64'(alu_ready), 64'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_wr_en", 64'(rf_write_en), 64'd0);
      check("t6_busy", 64'(busy), 64'd0);
      check("t6_mem_ready", 64'(mem_ready), 64'd1);
      check("t6_alu_ready", 64'(alu_ready), 64'd1);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("t6_no_stale", 64'(rf_write_en), 64'd0);
      end

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
